// File: rtl/sw_pkg.sv
// Shared constants for the switch debouncer.
//   SW_WIDTH_DEF          default number of switch bits
//   SW_STABLE_CYCLES_DEF  default debounce window (10 ms at 100 MHz)
//   SW_STABLE_CYCLES_SIM  short window for simulation
//   cnt_width()           counter width for a given window
package sw_pkg;

    localparam int unsigned SW_WIDTH_DEF         = 8;
    localparam int unsigned SW_STABLE_CYCLES_DEF = 1000000;
    localparam int unsigned SW_STABLE_CYCLES_SIM = 4;

    // Counter only needs to reach STABLE_CYCLES-1 before it clears.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit synchroniser and debouncer.
//   clk         system clock
//   rst_n       synchronous active-low reset
//   sw_raw      asynchronous switch pin
//   sw_stable   debounced value (registered)
//   sw_rise     one-cycle pulse after sw_stable goes 0->1
//   sw_fall     one-cycle pulse after sw_stable goes 1->0
//   stable_nxt  value sw_stable takes at the coming edge
//   upd         sw_stable changes at the coming edge
module debounce_bit
    import sw_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = SW_STABLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_stable,
    output logic sw_rise,
    output logic sw_fall,
    output logic stable_nxt,
    output logic upd
);

    if (STABLE_CYCLES < 2) begin : g_bad_param
        $error("debounce_bit: STABLE_CYCLES must be >= 2");
    end

    localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q;
    logic             rise_q;
    logic             fall_q;

    // Counter runs only while the synchronised bit disagrees with the
    // debounced value; any agreement (a bounce) restarts it from zero.
    always_comb begin
        cnt_d      = '0;
        stable_nxt = stable_q;
        upd        = 1'b0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_nxt = sync_q;
                upd        = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            meta_q   <= sw_raw;
            sync_q   <= meta_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_nxt;
            rise_q   <= upd & sync_q;
            fall_q   <= upd & ~sync_q;
        end
    end

    assign sw_stable = stable_q;
    assign sw_rise   = rise_q;
    assign sw_fall   = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a vector of slide switches and reports changes.
//   clk        system clock
//   rst_n      synchronous active-low reset
//   sw_raw     asynchronous switch pins
//   sw_stable  debounced switch vector
//   sw_rise    per-bit 0->1 pulses
//   sw_fall    per-bit 1->0 pulses
//   chg_valid  pending change event
//   chg_data   sw_stable snapshot for the pending event
//   chg_ready  consumer accepts the event
//   ovr        sticky: an event was overwritten before acceptance
//   ovr_clr    clears ovr (a simultaneous overwrite wins)
module switch_debouncer
    import sw_pkg::*;
#(
    parameter int unsigned WIDTH         = SW_WIDTH_DEF,
    parameter int unsigned STABLE_CYCLES = SW_STABLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             chg_valid,
    output logic [WIDTH-1:0] chg_data,
    input  logic             chg_ready,
    output logic             ovr,
    input  logic             ovr_clr
);

    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] upd_vec;
    logic             upd;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clk       (clk),
            .rst_n     (rst_n),
            .sw_raw    (sw_raw[i]),
            .sw_stable (sw_stable[i]),
            .sw_rise   (sw_rise[i]),
            .sw_fall   (sw_fall[i]),
            .stable_nxt(stable_nxt[i]),
            .upd       (upd_vec[i])
        );
    end

    assign upd = |upd_vec;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovr_q, ovr_d;

    // Single-entry buffer; a new update replaces an unaccepted event.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (upd) begin
            valid_d = 1'b1;
            data_d  = stable_nxt;
            if (valid_q && !chg_ready) begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && chg_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign chg_valid = valid_q;
    assign chg_data  = data_q;
    assign ovr       = ovr_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer with a short debounce window.
module tb_switch_debouncer;
    import sw_pkg::*;

    localparam int W = 8;
    localparam int S = SW_STABLE_CYCLES_SIM;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_stable;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         chg_valid;
    logic [W-1:0] chg_data;
    logic         chg_ready;
    logic         ovr;
    logic         ovr_clr;

    switch_debouncer #(
        .WIDTH        (W),
        .STABLE_CYCLES(S)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_raw   (sw_raw),
        .sw_stable(sw_stable),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .chg_valid(chg_valid),
        .chg_data (chg_data),
        .chg_ready(chg_ready),
        .ovr      (ovr),
        .ovr_clr  (ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // History of what was applied at each edge; the debounced value of a bit
    // flips when, for the last S edges, the pin value seen through a two-edge
    // delay differed from it and no reset occurred in that span.
    typedef struct {
        bit           rst;
        logic [W-1:0] raw;
    } samp_t;

    samp_t        hist[$];
    logic [W-1:0] sb_q[$];
    bit           model_live = 0;
    logic [W-1:0] exp_stable = '0;
    logic [W-1:0] exp_rise   = '0;
    logic [W-1:0] exp_fall   = '0;
    logic [W-1:0] exp_data   = '0;
    logic         exp_ovr    = 1'b0;

    // Pin value presented to the debouncer at edge k (0 if flushed by reset).
    function automatic logic [W-1:0] seen_at(input int k);
        if (k < 2) return '0;
        if (hist[k-1].rst || hist[k-2].rst) return '0;
        return hist[k-2].raw;
    endfunction

    function automatic bit flips(input int b);
        int           last;
        logic [W-1:0] v;
        last = hist.size() - 1;
        for (int j = 0; j < S; j++) begin
            if (last - j < 0) return 0;
            if (hist[last-j].rst) return 0;
            v = seen_at(last - j);
            if (v[b] == exp_stable[b]) return 0;
        end
        return 1;
    endfunction

    always @(posedge clk) begin
        samp_t        s;
        logic [W-1:0] chg;
        logic [W-1:0] nstable;
        s.rst = !rst_n;
        s.raw = sw_raw;
        hist.push_back(s);
        if (hist.size() > S + 3) hist.delete(0);
        if (!rst_n) begin
            model_live = 1;
            exp_stable = '0;
            exp_rise   = '0;
            exp_fall   = '0;
            exp_data   = '0;
            exp_ovr    = 1'b0;
            sb_q.delete();
        end else if (model_live) begin
            chg = '0;
            for (int b = 0; b < W; b++) chg[b] = flips(b);
            nstable    = exp_stable ^ chg;
            exp_rise   = chg & nstable;
            exp_fall   = chg & ~nstable;
            exp_stable = nstable;
            if (ovr_clr) exp_ovr = 1'b0;
            if (chg != '0) begin
                exp_data = nstable;
                if (sb_q.size() != 0) begin
                    // Event still pending and not taken: replaced in place.
                    sb_q[0] = nstable;
                    exp_ovr = 1'b1;
                end else begin
                    sb_q.push_back(nstable);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] front;
        if (model_live) begin
            chk("sw_stable", sw_stable, exp_stable);
            chk("sw_rise", sw_rise, exp_rise);
            chk("sw_fall", sw_fall, exp_fall);
            chk("ovr", W'(ovr), W'(exp_ovr));
            chk("chg_data_reg", chg_data, exp_data);
            chk("chg_valid", W'(chg_valid), W'(sb_q.size() != 0));
            if (chg_ready && (chg_valid || sb_q.size() != 0)) begin
                if (sb_q.size() == 0) begin
                    chk("chg_accept_unexpected", W'(chg_valid), W'(0));
                end else begin
                    front = sb_q.pop_front();
                    chk("chg_accept_data", chg_data, front);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        sw_raw    = 8'hFF;
        chg_ready = 1'b0;
        ovr_clr   = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(10);

        // Bounce on bit 0 after first settling it low.
        chg_ready = 1'b1;
        sw_raw    = 8'hFE;
        step(10);
        for (int i = 0; i < 10; i++) begin
            sw_raw[0] = ~sw_raw[0];
            step(2);
        end
        sw_raw[0] = 1'b1;
        step(10);

        // Handshake with consumer always ready.
        sw_raw = 8'h00;
        step(10);
        sw_raw = 8'h05;
        step(10);

        // Overrun, then clear, then drain.
        chg_ready = 1'b0;
        sw_raw    = 8'h01;
        step(8);
        sw_raw = 8'h03;
        step(8);
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        step(2);
        chg_ready = 1'b1;
        step(3);

        // Accept on the same edge a new update lands.
        chg_ready = 1'b0;
        sw_raw    = 8'h07;
        step(8);
        sw_raw = 8'h0F;
        step(5);
        chg_ready = 1'b1;
        step(1);
        chg_ready = 1'b0;
        step(3);
        chg_ready = 1'b1;
        step(2);

        // Reset mid-count discards the partial debounce.
        sw_raw = 8'h8F;
        step(3);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(10);

        // Randomised traffic.
        for (int it = 0; it < 400; it++) begin
            sw_raw    = sw_raw ^ (8'($urandom) & 8'($urandom));
            chg_ready = ($urandom_range(0, 2) != 0);
            ovr_clr   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 60) == 0) rst_n = 1'b0;
            step(1);
            ovr_clr = 1'b0;
            rst_n   = 1'b1;
            step($urandom_range(0, 8));
        end
        step(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
